// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Shares one 4:1 data mux between four valid/ready requesters and drives a
//   single registered output stream. Grants rotate round-robin, and a burst
//   limit bounds how many consecutive beats one owner may send.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       synchronous, active-low reset
//   req_valid_i  per-requester valid, bit i belongs to d<i>_i
//   d0_i..d3_i   requester data
//   req_ready_o  per-requester accept, one-hot or zero
//   out_valid_o  output register holds a beat
//   out_ready_i  downstream accepts the beat
//   y_o          registered output data
//   out_src_o    index of the requester that produced y_o
//   sel_o        current mux select, meaningful only when req_ready_o != 0
module rr_mux_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [3:0]   req_valid_i,
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  input  logic [W-1:0] d3_i,
  output logic [3:0]   req_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] y_o,
  output logic [1:0]   out_src_o,
  output logic [1:0]   sel_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   last_owner_q, last_owner_d;
  logic [3:0]   burst_q, burst_d;
  logic         out_valid_q;
  logic [W-1:0] y_q;
  logic [1:0]   out_src_q;

  logic         load_en_s;
  logic         any_req_s;
  logic         grant_s;
  logic [1:0]   gnt_s;
  logic [W-1:0] mux_data_s;

  // First valid index scanning p+1, p+2, p+3, then p itself (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign load_en_s = !out_valid_q || out_ready_i;
  assign any_req_s = |req_valid_i;

  // Arbitration: next-state and grant selection.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    grant_s      = 1'b0;
    gnt_s        = 2'd0;
    case (state_q)
      IDLE: begin
        if (load_en_s && any_req_s) begin
          gnt_s   = rr_pick(req_valid_i, last_owner_q);
          grant_s = 1'b1;
          state_d = BUSY;
          owner_d = gnt_s;
          burst_d = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!load_en_s) begin
          state_d = BUSY;
        end else if (req_valid_i[owner_q] && (burst_q < 4'(MAX_BURST))) begin
          gnt_s   = owner_q;
          grant_s = 1'b1;
          burst_d = burst_q + 4'd1;
        end else begin
          // Rotation grants the next requester in the same cycle, so no bubble.
          last_owner_d = owner_q;
          if (any_req_s) begin
            gnt_s   = rr_pick(req_valid_i, owner_q);
            grant_s = 1'b1;
            owner_d = gnt_s;
            burst_d = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Data mux driven by the current grant index.
  always_comb begin
    mux_data_s = '0;
    case (gnt_s)
      2'd0:    mux_data_s = d0_i;
      2'd1:    mux_data_s = d1_i;
      2'd2:    mux_data_s = d2_i;
      2'd3:    mux_data_s = d3_i;
      default: mux_data_s = d0_i;
    endcase
  end

  // Ready is suppressed while reset is asserted so no beat is accepted and lost.
  assign req_ready_o = (grant_s && rst_ni) ? (4'b0001 << gnt_s) : 4'b0000;
  assign sel_o       = gnt_s;

  // State and output register updates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      burst_q      <= 4'd0;
      out_valid_q  <= 1'b0;
      y_q          <= '0;
      out_src_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      if (load_en_s) begin
        if (grant_s) begin
          y_q         <= mux_data_s;
          out_src_q   <= gnt_s;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: instance a uses MAX_BURST=4, instance b
// uses MAX_BURST=1; both share the same stimulus.
module tb_rr_mux_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;

  logic [3:0] req_ready_a, req_ready_b;
  logic       out_valid_a, out_valid_b;
  logic [3:0] y_a, y_b;
  logic [1:0] out_src_a, out_src_b;
  logic [1:0] sel_a, sel_b;

  int total = 0;
  int bad   = 0;
  int sb_en = 0;
  logic [1:0] consumed[$];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.W(4), .MAX_BURST(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid),
    .d0_i(d0), .d1_i(d1), .d2_i(d2), .d3_i(d3),
    .req_ready_o(req_ready_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .y_o(y_a), .out_src_o(out_src_a), .sel_o(sel_a)
  );

  rr_mux_arbiter #(.W(4), .MAX_BURST(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid),
    .d0_i(d0), .d1_i(d1), .d2_i(d2), .d3_i(d3),
    .req_ready_o(req_ready_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .y_o(y_b), .out_src_o(out_src_b), .sel_o(sel_b)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: record a beat leaving instance a, then settle after the edge.
  task automatic step();
    if (sb_en != 0 && out_valid_a && out_ready) consumed.push_back(out_src_a);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
  endtask

  int exp_a[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
  int exp_b[9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int exp_c[4]  = '{3, 3, 3, 1};
  int exp_sb[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    rst_n = 1'b0; req_valid = 4'hf; out_ready = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    #1;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 8'(out_valid_a), 8'd0);
    chk("rst_y", 8'(y_a), 8'd0);
    chk("rst_out_src", 8'(out_src_a), 8'd0);
    chk("rst_req_ready", 8'(req_ready_a), 8'd0);
    chk("rst_out_valid_b", 8'(out_valid_b), 8'd0);

    // Reset priority and pure round robin
    rst_n = 1'b1;
    #1;
    chk("first_ready_a", 8'(req_ready_a), 8'b0001);
    chk("first_sel_a", 8'(sel_a), 8'd0);
    chk("first_ready_b", 8'(req_ready_b), 8'b0001);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("seq_valid_a", 8'(out_valid_a), 8'd1);
      chk("seq_src_a", 8'(out_src_a), 8'(exp_a[i]));
      chk("seq_y_a", 8'(y_a), 8'(exp_a[i] + 1));
      chk("rr_valid_b", 8'(out_valid_b), 8'd1);
      chk("rr_src_b", 8'(out_src_b), 8'(exp_b[i]));
    end

    // Owner drops mid-burst
    do_reset();
    req_valid = 4'b1010;
    rst_n = 1'b1;
    #1;
    chk("drop_first_sel", 8'(sel_a), 8'd1);
    step();
    chk("drop_beat0", 8'(out_src_a), 8'd1);
    step();
    chk("drop_beat1", 8'(out_src_a), 8'd1);
    req_valid = 4'b1000;
    #1;
    chk("drop_rotate_ready", 8'(req_ready_a), 8'b1000);
    step();
    chk("drop_src3", 8'(out_src_a), 8'd3);
    chk("drop_valid", 8'(out_valid_a), 8'd1);
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_burst_src", 8'(out_src_a), 8'(exp_c[i]));
    end

    // Single requester re-granted to itself without gaps
    do_reset();
    req_valid = 4'b0100;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("single_ready", 8'(req_ready_a), 8'b0100);
      step();
      chk("single_valid", 8'(out_valid_a), 8'd1);
      chk("single_src", 8'(out_src_a), 8'd2);
      chk("single_y", 8'(y_a), 8'd3);
    end

    // Backpressure with scoreboard
    do_reset();
    req_valid = 4'hf;
    rst_n = 1'b1;
    consumed.delete();
    sb_en = 1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 8'(req_ready_a), 8'd0);
      step();
      chk("stall_valid", 8'(out_valid_a), 8'd1);
      chk("stall_y", 8'(y_a), 8'd1);
      chk("stall_src", 8'(out_src_a), 8'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_resume_ready", 8'(req_ready_a), 8'b0001);
    for (int i = 0; i < 8; i++) step();
    sb_en = 0;
    chk("sb_count", 8'(consumed.size()), 8'd8);
    for (int i = 0; i < 8 && i < consumed.size(); i++)
      chk("sb_src", 8'(consumed[i]), 8'(exp_sb[i]));

    // Reset asserted mid-burst
    do_reset();
    req_valid = 4'b0010;
    rst_n = 1'b1;
    step();
    step();
    chk("mid_src", 8'(out_src_a), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 8'(req_ready_a), 8'd0);
    step();
    chk("mid_rst_valid", 8'(out_valid_a), 8'd0);
    chk("mid_rst_ready2", 8'(req_ready_a), 8'd0);
    req_valid = 4'hf;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 8'(req_ready_a), 8'b0001);
    step();
    chk("post_rst_src", 8'(out_src_a), 8'd0);
    chk("post_rst_y", 8'(y_a), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
